// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM states,
// default operand width and iteration-counter sizing.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_CALC = 2'd1,
    MS_DONE = 2'd2
  } mult_state_e;

  // Counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_unit_cond_neg.sv
// Conditional two's-complement negate: y = neg ? -x : x.
module cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier (mult/multu) producing a 2*WIDTH-bit product
// in hi/lo. Define MULT_EARLY_TERM_EN to stop as soon as the remaining multiplier bits are zero.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  mult_state_e      state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_next, prod;
  logic [WIDTH-1:0]   mplier_next;
  logic               last;

  cond_neg #(.W(WIDTH)) u_neg_a (.x(a), .neg(mult_sign & a[WIDTH-1]), .y(a_mag));
  cond_neg #(.W(WIDTH)) u_neg_b (.x(b), .neg(mult_sign & b[WIDTH-1]), .y(b_mag));
  cond_neg #(.W(2*WIDTH)) u_neg_p (.x(acc_next), .neg(neg_q), .y(prod));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    acc_next    = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_next = mplier_q >> 1;
    last        = (cnt_q == CW'(1));
`ifdef MULT_EARLY_TERM_EN
    last        = last || (mplier_next == '0);
`endif

    unique case (state_q)
      MS_IDLE, MS_DONE: begin
        state_d = MS_IDLE;
        if (start) begin
          state_d  = MS_CALC;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = mult_sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_d    = CW'(WIDTH);
          acc_d    = '0;
        end
      end
      MS_CALC: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_next;
        cnt_d    = cnt_q - CW'(1);
        if (last) begin
          {hi_d, lo_d} = prod;
          state_d      = MS_DONE;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MS_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == MS_CALC);
  assign done = (state_q == MS_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed products and latencies.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mult_sign;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mult_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mult_sign(mult_sign),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width product from ordinary integer multiplication.
  function automatic logic [63:0] model_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  // Number of busy cycles an operation takes.
  function automatic int calc_len(input logic [31:0] y, input logic s);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    m = (s && y[31]) ? (~y + 32'd1) : y;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
`else
    return 32;
`endif
  endfunction

  int          m_cnt;
  logic        m_done;
  logic [63:0] m_prod;
  logic [31:0] m_hi, m_lo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          {m_hi, m_lo} <= m_prod;
          m_done       <= 1'b1;
        end
      end else if (start) begin
        m_cnt  <= calc_len(b, mult_sign);
        m_prod <= model_prod(a, b, mult_sign);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 64'(busy), 64'(m_cnt != 0));
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_hilo", {hi, lo}, {m_hi, m_lo});
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [8];

  task automatic pulse(input logic [31:0] ia, input logic [31:0] ib, input logic s);
    a = ia; b = ib; mult_sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles from the start cycle (cycle 0) to the cycle where done is seen.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 1; nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_vec(input vec_t v, input string tag, output int lat);
    int nbusy;
    pulse(v.a, v.b, v.s);
    wait_done(lat, nbusy);
    check({tag, "_hi"}, 64'(hi), 64'(v.hi));
    check({tag, "_lo"}, 64'(lo), 64'(v.lo));
`ifndef MULT_EARLY_TERM_EN
    check({tag, "_lat"}, 64'(lat), 64'(33));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(32));
`endif
  endtask

  initial begin
    int lat, nbusy, seen;
    vec_t v;
    vecs = '{
      '{32'h00000003, 32'h00000005, 1'b0, 32'h00000000, 32'h0000000F},
      '{32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001},
      '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000},
      '{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000},
      '{32'hFFFFFFF9, 32'hFFFFFFFA, 1'b1, 32'h00000000, 32'h0000002A},
      '{32'h12345678, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001}
    };

    reset = 1'b1; start = 1'b0; mult_sign = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), lat);
      @(posedge clk); #1;
    end

    // Back-to-back: second start issued in the DONE cycle.
    run_vec(vecs[0], "b2b_first", lat);
    run_vec(vecs[1], "b2b_second", lat);
    @(posedge clk); #1;

    // Start during CALC must be ignored.
    v = vecs[2];
    pulse(v.a, v.b, v.s);
    repeat (5) begin @(posedge clk); #1; end
    pulse(32'h00000003, 32'h00000005, 1'b0);
    wait_done(lat, nbusy);
    check("midcalc_hi", 64'(hi), 64'(32'hFFFFFFFE));
    check("midcalc_lo", 64'(lo), 64'(32'h00000001));
    repeat (2) begin @(posedge clk); #1; end

    // Reset in the middle of an operation after a 0x1/0x2 result.
    v = '{32'h00000002, 32'h80000001, 1'b0, 32'h00000001, 32'h00000002};
    run_vec(v, "pre_reset", lat);
    @(posedge clk); #1;
    pulse(32'h00000003, 32'h00000005, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'(0));

`ifdef MULT_EARLY_TERM_EN
    pulse(32'h00000007, 32'h00000001, 1'b0);
    wait_done(lat, nbusy);
    check("et_small_lat", 64'(lat), 64'(2));
    check("et_small_lo", 64'(lo), 64'(7));
    @(posedge clk); #1;
    pulse(32'h00000007, 32'h80000000, 1'b0);
    wait_done(lat, nbusy);
    check("et_full_lat", 64'(lat), 64'(33));
    check("et_full_hi", 64'(hi), 64'(32'h00000003));
    check("et_full_lo", 64'(lo), 64'(32'h80000000));
`endif

    repeat (3) begin @(posedge clk); #1; end
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative shift-add multiplier in the EXE stage of the pipeline.
- Consumes the decoder's startmult/multsign controls and the two register-file operands.
- Produces the 2*WIDTH-bit product in HI/LO registers. The MEM-stage outselect mux reads these registers for mfhi/mflo.
- Drives busy so hazard logic can stall mfhi/mflo and new mult/multu instructions.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits; iteration count is WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  startmult from the controller; one-cycle request
- mult_sign  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with start
- a  input  WIDTH  multiplicand (rs value)
- b  input  WIDTH  multiplier (rt value)
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse; hi/lo hold the new product
- hi  output  WIDTH  upper half of the product
- lo  output  WIDTH  lower half of the product

Behaviour:
- Reset values (asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, internal accumulator and counters=0.
- States:
  - IDLE: start=1 -> CALC.
  - CALC: the iteration counter reaches its end -> DONE.
  - DONE: start=1 -> CALC; otherwise -> IDLE.
- Operand capture, at the edge where start=1 in IDLE or DONE:
  - If mult_sign=1, latch |a| and |b|, and record neg = a[MSB] ^ b[MSB].
  - If mult_sign=0, latch a and b unchanged, with neg=0.
  - |0x80000000| is 0x80000000; the captured value is treated as unsigned WIDTH bits.
  - Load the iteration counter with WIDTH and clear the 2*WIDTH accumulator.
- CALC, one multiplier bit per edge:
  - If the current multiplier LSB is 1, add the left-shifted multiplicand (2*WIDTH bits) to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1; decrement the counter.
  - On the final edge, write {hi,lo} = neg ? -(acc_next) : acc_next, using 2*WIDTH-bit two's complement.
- Latency: start sampled at edge E0; busy=1 in the cycles after E0 through EWIDTH; done=1 for exactly the one cycle after EWIDTH. For WIDTH=32, done appears 33 cycles after the start cycle.
- busy = (state==CALC); done = (state==DONE).
- hi/lo update only on the final CALC edge and otherwise hold, including through IDLE and the next CALC. They must not show partial products.
- start while in CALC: ignored; the operation in flight is not disturbed. Hazard logic must stall instead.
- start in the DONE cycle: accepted, giving back-to-back operation; done deasserts and busy asserts in the next cycle.
- reset mid-CALC: operation aborted, state->IDLE, hi/lo cleared, no done pulse.
- a or b equal to 0: still runs the full WIDTH iterations unless the optional feature is enabled.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined:
  - In CALC, if the shifted multiplier is zero after the current edge (remaining bits all 0), that edge is treated as the final edge: the result is written and state->DONE.
  - Latency ranges from 1 CALC cycle (b captured as 0 or 1) to WIDTH cycles.
  - Results are identical to the non-early-termination case.
- Undefined: the CALC length is always exactly WIDTH cycles.

Decomposition:
- Shared package mult_pkg:
  - state encoding localparams MS_IDLE=2'd0, MS_CALC=2'd1, MS_DONE=2'd2
  - default WIDTH constant
  - counter width $clog2(WIDTH+1)
- One natural sub-module, cond_neg: a parameterised conditional two's-complement negate.
  - Instantiated twice at WIDTH for operand magnitude.
  - Instantiated once at 2*WIDTH for the result sign fix.

Test Plan:
- Unsigned 3 x 5 (mult_sign=0): done exactly 33 cycles after start; hi=0x00000000, lo=0x0000000F; busy high 32 cycles.
- Signed -3 x 5 (a=0xFFFFFFFD, mult_sign=1) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000. Signed 0x80000000 x 1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Start pulsed again mid-CALC with different operands -> ignored; the original product is delivered. Start in the DONE cycle -> second product delivered 33 cycles later with no idle gap.
- Assert reset at CALC cycle 10 after a prior result hi/lo=0x1/0x2 -> hi=lo=0, busy=0, and no done pulse ever appears for the aborted operation.
- With MULT_EARLY_TERM_EN: 7 x 1 -> done 2 cycles after start with lo=7; 7 x 0x80000000 unsigned -> full 32-cycle latency, hi=0x00000003, lo=0x80000000.
